// File: rtl/odluka_mina_stijena.sv
// Decision stage for the mine/rock network.
// Realigns the two output-neuron probabilities with the sample strobe,
// classifies each sample against a confidence margin and majority-votes
// over a fixed window, emitting one registered decision per window.
//
// Handshake: there is no back-pressure. odluka_valid_o is a one-cycle pulse;
// klasa_o, nesiguran_o and glasovi_o are valid in that cycle and hold their
// value until the next pulse. Inputs are accepted every cycle.

module odluka_mina_stijena #(
    parameter int          LATENCIJA = 2,        // uzorak_valid -> probabilities delay (1..8)
    parameter int          PROZOR    = 8,        // samples per voting window (2..16)
    parameter logic [15:0] PRAG      = 16'h0800  // minimum |v0 - v1| for a certain sample
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        uzorak_valid_i,
    input  logic [15:0] vjerojatnost_0_i,
    input  logic [15:0] vjerojatnost_1_i,
    input  logic        novi_prozor_i,
    output logic        klasa_o,
    output logic        nesiguran_o,
    output logic [4:0]  glasovi_o,
    output logic        odluka_valid_o,
    output logic [1:0]  stanje_o
);

    typedef enum logic [1:0] {
        MIRUJE     = 2'd0,
        SKUPLJANJE = 2'd1,
        ODLUKA     = 2'd2
    } stanje_t;

    localparam logic [4:0]  PROZOR_N  = 5'(PROZOR);
    localparam logic [5:0]  POLA      = 6'(PROZOR / 2);
    localparam logic [16:0] PRAG_PROS = {1'b0, PRAG};

    // ------------------------------------------------------------------
    // Strobe realignment
    // ------------------------------------------------------------------
    logic [LATENCIJA-1:0] valid_niz_q;
    logic                 p_valid;

    generate
        if (LATENCIJA == 1) begin : g_kasnjenje_1
            // Single-stage delay line
            always_ff @(posedge clk_i) begin
                if (!rst_n_i) valid_niz_q <= '0;
                else          valid_niz_q <= uzorak_valid_i;
            end
        end else begin : g_kasnjenje_n
            // Shift the strobe so it lines up with the neuron outputs
            always_ff @(posedge clk_i) begin
                if (!rst_n_i) valid_niz_q <= '0;
                else          valid_niz_q <= {valid_niz_q[LATENCIJA-2:0], uzorak_valid_i};
            end
        end
    endgenerate

    assign p_valid = valid_niz_q[LATENCIJA-1];

    // ------------------------------------------------------------------
    // Per-sample classification
    // ------------------------------------------------------------------
    logic        v0_vece;
    logic [16:0] razlika;
    logic        siguran;
    logic        glas_mina;
    logic        glas_stijena;

    // Absolute difference and vote of the sample currently presented
    always_comb begin
        v0_vece = vjerojatnost_0_i > vjerojatnost_1_i;
        razlika = '0;
        if (v0_vece) begin
            razlika = {1'b0, vjerojatnost_0_i} - {1'b0, vjerojatnost_1_i};
        end else begin
            razlika = {1'b0, vjerojatnost_1_i} - {1'b0, vjerojatnost_0_i};
        end
        siguran      = razlika >= PRAG_PROS;
        glas_mina    = p_valid & siguran & v0_vece;
        glas_stijena = p_valid & siguran & ~v0_vece;
    end

    // ------------------------------------------------------------------
    // Window counters and decision
    // ------------------------------------------------------------------
    stanje_t    stanje_q;
    logic [4:0] n_uzoraka_q;
    logic [4:0] n_mina_q;
    logic [4:0] n_stijena_q;
    logic       klasa_q;
    logic       nesiguran_q;
    logic [4:0] glasovi_q;
    logic       odluka_valid_q;

    logic [4:0] n_uzoraka_d;
    logic [4:0] n_mina_d;
    logic [4:0] n_stijena_d;
    logic [4:0] prvi_uzorak;
    logic [4:0] prvi_mina;
    logic [4:0] prvi_stijena;
    logic       prozor_pun;
    logic [5:0] zbroj_glasova;
    logic       klasa_d;
    logic       nesiguran_d;

    // Counter values after accumulating this cycle's sample, the values a
    // freshly started window loads, and the decision over the updated counts
    always_comb begin
        n_uzoraka_d   = n_uzoraka_q + {4'd0, p_valid};
        n_mina_d      = n_mina_q + {4'd0, glas_mina};
        n_stijena_d   = n_stijena_q + {4'd0, glas_stijena};
        prvi_uzorak   = {4'd0, p_valid};
        prvi_mina     = {4'd0, glas_mina};
        prvi_stijena  = {4'd0, glas_stijena};
        prozor_pun    = p_valid && (n_uzoraka_d == PROZOR_N);
        zbroj_glasova = {1'b0, n_mina_d} + {1'b0, n_stijena_d};

        klasa_d = klasa_q;
        if (n_mina_d > n_stijena_d) begin
            klasa_d = 1'b1;
        end else if (n_stijena_d > n_mina_d) begin
            klasa_d = 1'b0;
        end
        nesiguran_d = (n_mina_d == n_stijena_d) || (zbroj_glasova < POLA);
    end

    // Window FSM: counting, registered decision, discard on novi_prozor
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            stanje_q       <= MIRUJE;
            n_uzoraka_q    <= '0;
            n_mina_q       <= '0;
            n_stijena_q    <= '0;
            klasa_q        <= 1'b0;
            nesiguran_q    <= 1'b0;
            glasovi_q      <= '0;
            odluka_valid_q <= 1'b0;
        end else begin
            odluka_valid_q <= 1'b0;
            case (stanje_q)
                MIRUJE, SKUPLJANJE: begin
                    if (novi_prozor_i) begin
                        // Drop the partial window; a coincident sample opens the next one
                        n_uzoraka_q <= prvi_uzorak;
                        n_mina_q    <= prvi_mina;
                        n_stijena_q <= prvi_stijena;
                        stanje_q    <= p_valid ? SKUPLJANJE : MIRUJE;
                    end else if (p_valid) begin
                        n_uzoraka_q <= n_uzoraka_d;
                        n_mina_q    <= n_mina_d;
                        n_stijena_q <= n_stijena_d;
                        if (prozor_pun) begin
                            // Decision is registered as the window fills, so the
                            // pulse is visible during the ODLUKA cycle
                            klasa_q        <= klasa_d;
                            nesiguran_q    <= nesiguran_d;
                            glasovi_q      <= n_mina_d;
                            odluka_valid_q <= 1'b1;
                            stanje_q       <= ODLUKA;
                        end else begin
                            stanje_q <= SKUPLJANJE;
                        end
                    end
                end
                ODLUKA: begin
                    // Counters restart; a sample arriving now is sample 1 of the next window
                    n_uzoraka_q <= prvi_uzorak;
                    n_mina_q    <= prvi_mina;
                    n_stijena_q <= prvi_stijena;
                    stanje_q    <= (novi_prozor_i && !p_valid) ? MIRUJE : SKUPLJANJE;
                end
                default: begin
                    n_uzoraka_q <= '0;
                    n_mina_q    <= '0;
                    n_stijena_q <= '0;
                    stanje_q    <= MIRUJE;
                end
            endcase
        end
    end

    assign klasa_o        = klasa_q;
    assign nesiguran_o    = nesiguran_q;
    assign glasovi_o      = glasovi_q;
    assign odluka_valid_o = odluka_valid_q;
    assign stanje_o       = stanje_q;

endmodule

// File: tb/tb_odluka_mina_stijena.sv
// Bench for odluka_mina_stijena: directed windows from the plan plus random
// traffic, checked against a window-level vote model via an expected queue.

module tb_odluka_mina_stijena;

    localparam int          LAT  = 2;
    localparam int          WIN  = 8;
    localparam logic [15:0] PRAG = 16'h0800;

    logic        clk_i;
    logic        rst_n_i;
    logic        uzorak_valid_i;
    logic [15:0] vjerojatnost_0_i;
    logic [15:0] vjerojatnost_1_i;
    logic        novi_prozor_i;
    logic        klasa_o;
    logic        nesiguran_o;
    logic [4:0]  glasovi_o;
    logic        odluka_valid_o;
    logic [1:0]  stanje_o;

    odluka_mina_stijena #(
        .LATENCIJA(LAT),
        .PROZOR   (WIN),
        .PRAG     (PRAG)
    ) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .uzorak_valid_i  (uzorak_valid_i),
        .vjerojatnost_0_i(vjerojatnost_0_i),
        .vjerojatnost_1_i(vjerojatnost_1_i),
        .novi_prozor_i   (novi_prozor_i),
        .klasa_o         (klasa_o),
        .nesiguran_o     (nesiguran_o),
        .glasovi_o       (glasovi_o),
        .odluka_valid_o  (odluka_valid_o),
        .stanje_o        (stanje_o)
    );

    // ---------------- clock / reset / cycle counter ----------------
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int cyc = 0;
    always @(posedge clk_i) cyc = cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int         checks   = 0;
    int         failures = 0;
    logic [6:0] exp_q[$];          // {klasa, nesiguran, glasovi}
    int         due_q[$];          // cycle in which each pulse must be seen
    logic [6:0] held     = '0;
    logic       mon_on   = 1'b0;

    // stimulus pipeline: {valid, v0, v1} reaching the decision stage LAT slots later
    logic [32:0] pipe_q[$];

    // window-level reference model
    int   win_n, win_m, win_s;
    logic model_klasa;

    task automatic model_cycle(input logic pv, input logic [15:0] a, input logic [15:0] b,
                               input logic np);
        int d;
        logic [6:0] e;
        logic k, n;
        if (np) begin
            win_n = 0; win_m = 0; win_s = 0;
        end
        if (pv) begin
            d = (a > b) ? int'(a) - int'(b) : int'(b) - int'(a);
            if (d >= int'(PRAG)) begin
                if (a > b) win_m++;
                else       win_s++;
            end
            win_n++;
            if (win_n == WIN) begin
                if (win_m > win_s)      k = 1'b1;
                else if (win_s > win_m) k = 1'b0;
                else                    k = model_klasa;
                n = (win_m == win_s) || ((win_m + win_s) < WIN / 2);
                model_klasa = k;
                e = {k, n, 5'(win_m)};
                exp_q.push_back(e);
                due_q.push_back(cyc + 1);
                win_n = 0; win_m = 0; win_s = 0;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic np);
        logic [32:0] e;
        uzorak_valid_i = v;
        novi_prozor_i  = np;
        pipe_q.push_back({v, a, b});
        e = pipe_q.pop_front();
        if (e[32]) begin
            vjerojatnost_0_i = e[31:16];
            vjerojatnost_1_i = e[15:0];
        end else begin
            vjerojatnost_0_i = 16'($urandom);
            vjerojatnost_1_i = 16'($urandom);
        end
        model_cycle(e[32], e[31:16], e[15:0], np);
        @(posedge clk_i); #1;
    endtask

    task automatic sample(input logic [15:0] a, input logic [15:0] b);
        step(1'b1, a, b, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic do_reset();
        mon_on         = 1'b0;
        rst_n_i        = 1'b0;
        uzorak_valid_i = 1'b0;
        novi_prozor_i  = 1'b0;
        pipe_q.delete();
        for (int i = 0; i < LAT; i++) pipe_q.push_back('0);
        win_n = 0; win_m = 0; win_s = 0;
        model_klasa = 1'b0;
        held = '0;
        repeat (3) begin
            @(posedge clk_i); #1;
        end
        rst_n_i = 1'b1;
        mon_on  = 1'b1;
    endtask

    task automatic rand_pair(output logic [15:0] a, output logic [15:0] b);
        int mode, base, diff;
        mode = $urandom_range(0, 3);
        if (mode == 0) begin
            a = 16'($urandom);
            b = 16'($urandom);
        end else begin
            case ($urandom_range(0, 3))
                0:       diff = int'(PRAG) - 1;
                1:       diff = int'(PRAG);
                2:       diff = int'(PRAG) + 1;
                default: diff = 0;
            endcase
            base = $urandom_range(0, 16'hFFFF - 16'h0801);
            if ($urandom_range(0, 1) == 1) begin
                a = 16'(base + diff); b = 16'(base);
            end else begin
                a = 16'(base); b = 16'(base + diff);
            end
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk_i) begin
        logic [6:0] act;
        logic [6:0] e;
        int         d;
        if (mon_on && rst_n_i) begin
            act = {klasa_o, nesiguran_o, glasovi_o};
            checks++;
            if (odluka_valid_o) begin
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL spurious_pulse: cyc=%0d got klasa=%0b nesiguran=%0b glasovi=%0d, expected no pulse",
                             cyc, klasa_o, nesiguran_o, glasovi_o);
                    held = act;
                end else begin
                    e = exp_q.pop_front();
                    d = due_q.pop_front();
                    if (act !== e || cyc != d) begin
                        failures++;
                        $display("FAIL decision: cyc=%0d got k=%0b n=%0b g=%0d, required cyc=%0d k=%0b n=%0b g=%0d",
                                 cyc, act[6], act[5], act[4:0], d, e[6], e[5], e[4:0]);
                    end
                    held = e;
                end
            end else begin
                if (act !== held) begin
                    failures++;
                    $display("FAIL hold: cyc=%0d got k=%0b n=%0b g=%0d, required k=%0b n=%0b g=%0d",
                             cyc, act[6], act[5], act[4:0], held[6], held[5], held[4:0]);
                end
                if (due_q.size() > 0 && due_q[0] < cyc) begin
                    failures++;
                    $display("FAIL missing_pulse: cyc=%0d no pulse, required one at cyc=%0d", cyc, due_q[0]);
                    void'(due_q.pop_front());
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- scenarios ----------------
    initial begin
        logic [15:0] a, b;
        rst_n_i          = 1'b0;
        uzorak_valid_i   = 1'b0;
        novi_prozor_i    = 1'b0;
        vjerojatnost_0_i = '0;
        vjerojatnost_1_i = '0;
        #1;
        do_reset();

        // idle after reset: outputs stay 0, no pulses
        idle(20);

        // 8 clear mine samples
        for (int i = 0; i < 8; i++) sample(16'hE000, 16'h2000);
        idle(5);

        // 5 rock + 3 mine, interleaved
        for (int i = 0; i < 8; i++) begin
            if (i % 3 == 1) sample(16'hE000, 16'h2000);
            else            sample(16'h1000, 16'hF000);
        end
        idle(5);

        // 6 uncertain + 2 mine
        for (int i = 0; i < 6; i++) sample(16'h8000, 16'h8400);
        sample(16'hE000, 16'h2000);
        sample(16'hE000, 16'h2000);
        idle(5);

        // 4 mine + 4 rock: tie keeps previous klasa
        for (int i = 0; i < 4; i++) sample(16'hE000, 16'h2000);
        for (int i = 0; i < 4; i++) sample(16'h1000, 16'hF000);
        idle(5);

        // threshold boundaries: exactly PRAG is certain, PRAG-1 and equal are not
        sample(16'h4800, 16'h4000);
        sample(16'h4000, 16'h4800);
        sample(16'h47FF, 16'h4000);
        sample(16'h4000, 16'h47FF);
        sample(16'h5555, 16'h5555);
        sample(16'hFFFF, 16'h0000);
        sample(16'h0000, 16'hFFFF);
        sample(16'h0801, 16'h0000);
        idle(5);

        // 16 back-to-back strobes: two pulses 8 apart, no loss at the boundary
        for (int i = 0; i < 16; i++) begin
            if (i == 8 || i == 12) sample(16'h1000, 16'hF000);
            else                   sample(16'hE000, 16'h2000);
        end
        idle(5);

        // novi_prozor after 5 delivered samples, then a fresh window
        for (int i = 0; i < 5; i++) sample(16'h1000, 16'hF000);
        idle(3);
        step(1'b0, 16'h0, 16'h0, 1'b1);
        for (int i = 0; i < 8; i++) sample(16'hE000, 16'h2000);
        idle(5);

        // reset after 5 samples with strobes still in flight
        for (int i = 0; i < 5; i++) sample(16'hE000, 16'h2000);
        do_reset();
        for (int i = 0; i < 8; i++) sample(16'h1000, 16'hF000);
        idle(5);

        // random traffic, including novi_prozor at arbitrary points
        for (int i = 0; i < 500; i++) begin
            rand_pair(a, b);
            step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, a, b,
                 ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
        end
        idle(10);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d decisions never seen, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/odluka_mina_stijena.md
Name: odluka_mina_stijena

Overview:
- Decision stage directly downstream of the two output-layer neurons of the mine/rock network.
- Consumes the two 16-bit sigmoid probabilities each clock.
- Realigns them with the sample-valid strobe and classifies each sample (mine vs rock) against a confidence margin.
- Majority-votes over a window of samples and emits one registered decision per window, with a valid pulse.

Parameters:
- LATENCIJA, 2: clock cycles from uzorak_valid to the matching probabilities appearing on vjerojatnost_0/1 (legal 1..8).
- PROZOR, 8: samples per voting window (legal 2..16).
- PRAG, 16'h0800: minimum |vjerojatnost_0 - vjerojatnost_1| for a sample to be counted as certain.

Ports:
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  synchronous active-low reset
- uzorak_valid  in  1  high in the cycle an 80-bit sample is presented to the hidden layer
- vjerojatnost_0  in  16  output-neuron 1 probability (mine), unsigned fraction, 16'hFFFF ≈ 1.0
- vjerojatnost_1  in  16  output-neuron 2 probability (rock), same format
- novi_prozor  in  1  synchronous discard of the partial window
- klasa  out  1  1 = mine, 0 = rock; holds between decisions
- nesiguran  out  1  decision flagged low-confidence; holds between decisions
- glasovi  out  5  mine votes in the last window; holds between decisions
- odluka_valid  out  1  one-cycle pulse when klasa/nesiguran/glasovi update

Behaviour:
- Reset (rst_n=0 at posedge):
  - klasa=0, nesiguran=0, glasovi=0, odluka_valid=0.
  - Valid delay line cleared; all counters 0; state MIRUJE.
- Alignment:
  - uzorak_valid is shifted through a LATENCIJA-deep register chain, producing p_valid.
  - Probabilities are sampled only in cycles where p_valid=1; otherwise they are ignored.
- Per-sample classification (combinational on p_valid):
  - Form 17-bit razlika = |v0 - v1|.
  - Certain if razlika >= PRAG (no overflow is possible).
  - Certain sample votes mine when v0 > v1; rock when v1 >= v0.
  - An uncertain sample increments the window count but no vote counter.
- Counters (5 bits each): n_uzoraka, n_mina, n_stijena.
- States:
  - MIRUJE: on p_valid, count the sample and go SKUPLJANJE.
  - SKUPLJANJE:
    - On p_valid, count the sample.
    - If n_uzoraka reaches PROZOR with this sample, go ODLUKA.
  - ODLUKA (exactly 1 cycle):
    - Register odluka_valid=1 and glasovi=n_mina.
    - klasa = 1 if n_mina>n_stijena, 0 if n_stijena>n_mina, unchanged if equal.
    - nesiguran = 1 if n_mina==n_stijena or (n_mina+n_stijena) < PROZOR/2.
    - Clear counters; next state SKUPLJANJE.
    - A p_valid in this same cycle is counted as sample 1 of the new window (counter loads 1, not 0).
- Latency: the window-completing uzorak_valid at cycle t gives p_valid at t+LATENCIJA and odluka_valid high at t+LATENCIJA+1.
- odluka_valid is low in every other cycle. Back-to-back samples are supported at 1 sample/clock, with no gaps required.
- novi_prozor=1:
  - Clears counters; state goes to MIRUJE.
  - A coincident p_valid is counted as sample 1, so the state goes to SKUPLJANJE.
  - If coincident with ODLUKA, the decision is still issued; only the carried-over sample handling applies.
  - Outputs klasa/nesiguran/glasovi are not changed.
  - The delay line is not cleared.
- rst_n low mid-window:
  - Discards everything, including in-flight delay-line entries.
  - No odluka_valid is issued for the aborted window.

Test Plan:
- Reset then idle 20 cycles -> all outputs 0, odluka_valid never high.
- 8 consecutive uzorak_valid with v0=16'hE000, v1=16'h2000 -> one odluka_valid pulse 3 cycles after the 8th strobe; klasa=1, glasovi=8, nesiguran=0.
- Window of 5 rock (v0=16'h1000, v1=16'hF000) and 3 mine samples -> klasa=0, glasovi=3, nesiguran=0.
- Window of 6 samples with v0=16'h8000, v1=16'h8400 (razlika < PRAG) plus 2 mine samples -> klasa=1, glasovi=2, nesiguran=1.
- 4 mine + 4 rock after a previous klasa=1 -> klasa stays 1, nesiguran=1, glasovi=4.
- 16 continuous strobes -> two pulses exactly 8 cycles apart, with no sample lost at the ODLUKA boundary.
- novi_prozor after 5 samples, then 8 more samples -> exactly one pulse, covering only the 8 new samples.
- rst_n low after 5 samples, then 8 more samples -> exactly one pulse, covering only the 8 new samples.
